// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg
// Shared definitions for the multiply/divide sequencer and its datapath:
// operation encodings, FSM state encodings and the default operand width
// used by the execute-stage datapath.
package ex_muldiv_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_DIVU = 2'b01
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/ex_muldiv_datapath.sv
// ex_muldiv_datapath
// Shift/accumulate datapath shared by unsigned multiply (shift-add) and
// unsigned divide (restoring division).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load          capture operands and clear the accumulator/remainder
//   step          perform one iteration
//   div           1 = divide (load and step), 0 = multiply
//   a, b          operands (a = multiplicand/dividend, b = multiplier/divisor)
//   next_hi/lo    register contents after this cycle's load/step; after the
//                 final step this is {product hi, lo} or {remainder, quotient}
module ex_muldiv_datapath
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  // acc: upper accumulator (MUL) / partial remainder (DIV)
  // mq : multiplier being shifted out (MUL) / dividend->quotient (DIV)
  // opnd: multiplicand (MUL) / divisor (DIV)
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] mq, mq_n;
  logic [WIDTH-1:0] opnd, opnd_n;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    acc_n   = acc;
    mq_n    = mq;
    opnd_n  = opnd;
    // Carry is kept in sum[WIDTH] and shifted down into acc.
    sum     = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    shifted = {acc, mq[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};

    if (load) begin
      acc_n  = '0;
      opnd_n = div ? b : a;
      mq_n   = div ? a : b;
    end else if (step) begin
      if (div) begin
        if (!diff[WIDTH]) begin
          acc_n = diff[WIDTH-1:0];
          mq_n  = {mq[WIDTH-2:0], 1'b1};
        end else begin
          acc_n = shifted[WIDTH-1:0];
          mq_n  = {mq[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_n = sum[WIDTH:1];
        mq_n  = {sum[0], mq[WIDTH-1:1]};
      end
    end

    next_hi = acc_n;
    next_lo = mq_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      mq   <= '0;
      opnd <= '0;
    end else begin
      acc  <= acc_n;
      mq   <= mq_n;
      opnd <= opnd_n;
    end
  end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer
// Multi-cycle unsigned MULU/DIVU sequencer beside the execute stage. Holds
// the pipeline via O_Stall while iterating and delivers the 2*WIDTH result
// into the Hi/Lo architectural registers.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_Start      request an operation this cycle
//   in_Op         00 = MULU, 01 = DIVU, others ignored
//   in_A, in_B    execute-stage operands
//   in_Flush      abort in-flight operation / block acceptance
//   O_Busy        iterating (MUL or DIV)
//   O_Stall       pipeline hold request
//   O_Done        one-cycle completion pulse, Hi/Lo valid
//   O_Hi, O_Lo    MULU: product hi/lo; DIVU: remainder/quotient
//   O_DivByZero   last completed DIVU had a zero divisor
module ex_muldiv_sequencer
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_Start,
  input  logic [1:0]       in_Op,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             in_Flush,
  output logic             O_Busy,
  output logic             O_Stall,
  output logic             O_Done,
  output logic [WIDTH-1:0] O_Hi,
  output logic [WIDTH-1:0] O_Lo,
  output logic             O_DivByZero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e          state, state_n;
  logic [CW-1:0]   cnt;
  logic            op_valid;
  logic            op_div;
  logic            accept;
  logic            div_zero;
  logic            dp_load;
  logic            dp_step;
  logic            dp_div;
  logic [WIDTH-1:0] dp_hi;
  logic [WIDTH-1:0] dp_lo;

  always_comb begin
    op_valid = (in_Op == OP_MULU) || (in_Op == OP_DIVU);
    op_div   = (in_Op == OP_DIVU);
    accept   = in_Start & op_valid & ~in_Flush &
               ((state == ST_IDLE) || (state == ST_DONE));
    div_zero = accept & op_div & (in_B == '0);

    O_Busy   = (state == ST_MUL) || (state == ST_DIV);
    O_Stall  = O_Busy | accept;
    O_Done   = (state == ST_DONE);

    dp_load  = accept & ~div_zero;
    dp_step  = O_Busy & ~in_Flush;
    dp_div   = accept ? op_div : (state == ST_DIV);

    state_n = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (div_zero)    state_n = ST_DONE;
        else if (accept) state_n = op_div ? ST_DIV : ST_MUL;
        else             state_n = ST_IDLE;
      end
      ST_MUL, ST_DIV: begin
        if (in_Flush)              state_n = ST_IDLE;
        else if (cnt == CW'(1))    state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  ex_muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .load    (dp_load),
    .step    (dp_step),
    .div     (dp_div),
    .a       (in_A),
    .b       (in_B),
    .next_hi (dp_hi),
    .next_lo (dp_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      O_Hi        <= '0;
      O_Lo        <= '0;
      O_DivByZero <= 1'b0;
    end else begin
      state <= state_n;

      if (accept)      cnt <= CW'(WIDTH);
      else if (O_Busy) cnt <= cnt - CW'(1);

      // The final iteration and the Hi/Lo capture share one edge, so Hi/Lo
      // take the datapath's post-step value rather than its registers.
      if (state_n == ST_DONE) begin
        if (div_zero) begin
          O_Hi        <= in_A;
          O_Lo        <= '1;
          O_DivByZero <= 1'b1;
        end else begin
          O_Hi        <= dp_hi;
          O_Lo        <= dp_lo;
          O_DivByZero <= 1'b0;
        end
      end
    end
  end

endmodule
